lut_divider_32b_seq: RTL and testbench

- Sequential 32-bit unsigned divider: the inverse of the team's radix-16 LUT multiplier.
- Builds a lookup table of divisor multiples (1..15 × divisor), then retires one 4-bit quotient digit per clock, MSB nibble first.
- Sits beside lut_multiplier_32b in the arithmetic datapath and uses a start/busy/done handshake.

---
 rtl/lut_divider_32b_seq.sv | 128 ++++++++++++
 tb/tb_lut_divider_32b_seq.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_divider_32b_seq.sv
// Sequential 32-bit unsigned divider, radix-16 digit recurrence driven by a
// table of divisor multiples built one entry per clock before the digit loop.
module lut_divider_32b_seq #(
    parameter logic [31:0] DBZ_QUOTIENT = 32'hFFFF_FFFF
) (
    input  logic        clk_32b,
    input  logic        resetn_32b,
    input  logic        start_32b,
    input  logic [31:0] dividend_32b,
    input  logic [31:0] divisor_32b,
    output logic        busy_32b,
    output logic        done_32b,
    output logic [31:0] quotient_32b,
    output logic [31:0] remainder_32b,
    output logic        div_by_zero_32b
);

    typedef enum logic [1:0] {IDLE, FILL, DIV, DONE} state_t;

    state_t      state_q;
    logic [35:0] table_q [16];
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] quo_q;
    logic [35:0] rem_q;
    logic [3:0]  k_q;
    logic [3:0]  cnt_q;
    logic        dbz_q;
    logic        busy_q;
    logic        done_q;
    logic        dbz_out_q;
    logic [31:0] quotient_q;
    logic [31:0] remainder_q;

    logic [35:0] rp_d;
    logic [35:0] rem_d;
    logic [3:0]  digit_d;

    // Table is monotonic, so the last entry not exceeding r' is the digit.
    always_comb begin
        rp_d    = (rem_q << 4) | {32'b0, dvd_q[31:28]};
        digit_d = '0;
        for (int k = 1; k < 16; k++) begin
            if (table_q[k] <= rp_d) digit_d = 4'(k);
        end
        rem_d = rp_d - table_q[digit_d];
    end

    always_ff @(posedge clk_32b or negedge resetn_32b) begin
        if (!resetn_32b) begin
            state_q     <= IDLE;
            for (int k = 0; k < 16; k++) table_q[k] <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dbz_out_q   <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_32b) begin
                        dvd_q      <= dividend_32b;
                        dvs_q      <= divisor_32b;
                        table_q[1] <= {4'b0, divisor_32b};
                        busy_q     <= 1'b1;
                        dbz_out_q  <= 1'b0;
                        rem_q      <= '0;
                        quo_q      <= '0;
                        k_q        <= 4'd2;
                        dbz_q      <= (divisor_32b == 32'd0);
                        // Divide-by-zero skips straight to the commit step.
                        if (divisor_32b == 32'd0) begin
                            cnt_q   <= 4'd8;
                            state_q <= DIV;
                        end else begin
                            cnt_q   <= 4'd0;
                            state_q <= FILL;
                        end
                    end
                end
                FILL: begin
                    table_q[k_q] <= table_q[k_q - 4'd1] + {4'b0, dvs_q};
                    k_q          <= k_q + 4'd1;
                    if (k_q == 4'd15) state_q <= DIV;
                end
                DIV: begin
                    if (cnt_q[3]) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                        if (dbz_q) begin
                            quotient_q  <= DBZ_QUOTIENT;
                            remainder_q <= dvd_q;
                            dbz_out_q   <= 1'b1;
                        end else begin
                            quotient_q  <= quo_q;
                            remainder_q <= rem_q[31:0];
                        end
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= {quo_q[27:0], digit_d};
                        dvd_q <= dvd_q << 4;
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_32b        = busy_q;
    assign done_32b        = done_q;
    assign quotient_32b    = quotient_q;
    assign remainder_32b   = remainder_q;
    assign div_by_zero_32b = dbz_out_q;

endmodule

// File: tb/tb_lut_divider_32b_seq.sv
// Directed bench for lut_divider_32b_seq: results, latency, handshake, reset.
module tb_lut_divider_32b_seq;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic        busy;
    logic        done;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        dbz;

    int checks = 0;
    int failures = 0;

    lut_divider_32b_seq dut (
        .clk_32b        (clk),
        .resetn_32b     (rstn),
        .start_32b      (start),
        .dividend_32b   (dvd),
        .divisor_32b    (dvs),
        .busy_32b       (busy),
        .done_32b       (done),
        .quotient_32b   (quo),
        .remainder_32b  (rem),
        .div_by_zero_32b(dbz)
    );

    always #5 clk = ~clk;

    // Issue one operation and wait (bounded) for done; lat=-1 on timeout.
    task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                           output int lat);
        dvd   = a;
        dvs   = b;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn  = 1'b0;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, dbz} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000", {busy, done, dbz});
        end
        checks++;
        if (quo !== 32'd0 || rem !== 32'd0) begin
            failures++;
            $display("FAIL reset_data got q=%h r=%h exp 0/0", quo, rem);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat;
        run_div(32'd100, 32'd7, lat);
        checks++;
        if (lat !== 23) begin
            failures++;
            $display("FAIL basic_latency got=%0d exp=23", lat);
        end
        checks++;
        if (quo !== 32'd14 || rem !== 32'd2 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL basic_result got q=%0d r=%0d z=%b exp 14/2/0",
                     quo, rem, dbz);
        end
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_in_done got=%b exp=1", busy);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL basic_after_done got busy=%b done=%b exp 0/0",
                     busy, done);
        end
        checks++;
        if (quo !== 32'd14 || rem !== 32'd2) begin
            failures++;
            $display("FAIL basic_hold got q=%0d r=%0d exp 14/2", quo, rem);
        end
    endtask

    task automatic test_full_range;
        logic [31:0] va [3] = '{32'hDEADBEEF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] vb [3] = '{32'h00001234, 32'h00000001, 32'hFFFFFFFF};
        logic [31:0] eq [3] = '{32'h000C3BA5, 32'hFFFFFFFF, 32'h00000001};
        logic [31:0] er [3] = '{32'h0000076B, 32'h00000000, 32'h00000000};
        int lat;
        for (int i = 0; i < 3; i++) begin
            run_div(va[i], vb[i], lat);
            checks++;
            if (lat !== 23 || quo !== eq[i] || rem !== er[i]) begin
                failures++;
                $display("FAIL full_range[%0d] got lat=%0d q=%h r=%h exp 23 %h %h",
                         i, lat, quo, rem, eq[i], er[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_div_by_zero;
        int lat;
        run_div(32'd5, 32'd0, lat);
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("FAIL dbz_latency got=%0d exp=1", lat);
        end
        checks++;
        if (quo !== 32'hFFFFFFFF || rem !== 32'd5 || dbz !== 1'b1) begin
            failures++;
            $display("FAIL dbz_result got q=%h r=%0d z=%b exp ffffffff/5/1",
                     quo, rem, dbz);
        end
        @(negedge clk);
        checks++;
        if (dbz !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL dbz_hold got z=%b busy=%b exp 1/0", dbz, busy);
        end
        run_div(32'd9, 32'd3, lat);
        checks++;
        if (lat !== 23 || quo !== 32'd3 || rem !== 32'd0 || dbz !== 1'b0) begin
            failures++;
            $display("FAIL after_dbz got lat=%0d q=%0d r=%0d z=%b exp 23 3/0/0",
                     lat, quo, rem, dbz);
        end
        @(negedge clk);
    endtask

    task automatic test_small;
        int lat;
        run_div(32'd3, 32'd10, lat);
        checks++;
        if (quo !== 32'd0 || rem !== 32'd3) begin
            failures++;
            $display("FAIL small got q=%0d r=%0d exp 0/3", quo, rem);
        end
        @(negedge clk);
        run_div(32'd0, 32'h80000000, lat);
        checks++;
        if (lat !== 23 || quo !== 32'd0 || rem !== 32'd0) begin
            failures++;
            $display("FAIL zero_dividend got lat=%0d q=%0d r=%0d exp 23 0/0",
                     lat, quo, rem);
        end
        @(negedge clk);
    endtask

    task automatic test_handshake;
        int ndone = 0;
        int first = -1;
        logic busy24 = 1'b1;
        dvd   = 32'd1000;
        dvs   = 32'd9;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int n = 1; n <= 34; n++) begin
            start = (n == 5 || n == 23 || n == 24);
            if (n == 3) begin
                dvd = 32'd77777;
                dvs = 32'd3;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first < 0) first = n;
            end
            if (n == 24) busy24 = busy;
            if (n == 24) start = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || first !== 23) begin
            failures++;
            $display("FAIL ignore_start got done_count=%0d at=%0d exp 1 at 23",
                     ndone, first);
        end
        checks++;
        if (quo !== 32'd111 || rem !== 32'd1) begin
            failures++;
            $display("FAIL mid_run_change got q=%0d r=%0d exp 111/1", quo, rem);
        end
        checks++;
        if (busy24 !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL not_queued got busy=%b/%b exp 0/0", busy24, busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        int lat2 = -1;
        run_div(32'd1000, 32'd10, lat);
        checks++;
        if (lat !== 23 || quo !== 32'd100 || rem !== 32'd0) begin
            failures++;
            $display("FAIL b2b_first got lat=%0d q=%0d r=%0d exp 23 100/0",
                     lat, quo, rem);
        end
        dvd   = 32'd123456;
        dvs   = 32'd1000;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle_gap got busy=%b exp=0", busy);
        end
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept got busy=%b exp=1", busy);
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat2 = n;
                break;
            end
        end
        checks++;
        if (lat2 !== 23 || quo !== 32'd123 || rem !== 32'd456) begin
            failures++;
            $display("FAIL b2b_second got lat=%0d q=%0d r=%0d exp 23 123/456",
                     lat2, quo, rem);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        int lat;
        int ndone = 0;
        dvd   = 32'd1000;
        dvs   = 32'd9;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({busy, done, dbz} !== 3'b000 || quo !== 32'd0 || rem !== 32'd0) begin
            failures++;
            $display("FAIL async_reset got b=%b d=%b z=%b q=%h r=%h exp all 0",
                     busy, done, dbz, quo, rem);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            failures++;
            $display("FAIL reset_abort got active_cycles=%0d exp=0", ndone);
        end
        run_div(32'd50, 32'd5, lat);
        checks++;
        if (lat !== 23 || quo !== 32'd10 || rem !== 32'd0) begin
            failures++;
            $display("FAIL post_reset got lat=%0d q=%0d r=%0d exp 23 10/0",
                     lat, quo, rem);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_range();
        test_div_by_zero();
        test_small();
        test_handshake();
        test_back_to_back();
        test_reset_mid_op();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
